mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Sequential data-memory access unit for the MEM stage. It replaces the combinational select/strobe generator with a full request/response engine.
- Decodes MIPS load/store opcodes, checks alignment, drives an SRAM-like data bus (req/addr_ok/data_ok), stalls the pipeline while a transaction is outstanding, and returns the extended load result.
- Optionally supports LWL/LWR/SWL/SWR.
- Handles flush with an outstanding transaction by draining it and discarding the data.

Parameters:
- ADDR_W, 32, bus address width; addr[1:0] is the byte offset.
- UNALIGNED_EN, 1, 1 = LWL/LWR/SWL/SWR decoded; 0 = those opcodes are treated as non-memory ops.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  MEM-stage instruction valid
- op_code  in  6  instruction opcode (EXE_* encodings from defines.vh)
- addr  in  ADDR_W  effective address
- write_data  in  32  rt value for stores
- rt_old  in  32  current rt value, used to merge LWL/LWR results
- flush  in  1  exception/eret flush of the MEM stage
- stall_o  out  1  hold the pipeline
- resp_valid  out  1  one-cycle pulse: load/store completed
- load_data  out  32  extended/merged load result, valid with resp_valid
- addrErrorLw  out  1  misaligned load (combinational)
- addrErrorSw  out  1  misaligned store (combinational)
- data_sram_req  out  1  bus request
- data_sram_wr  out  1  1 = store
- data_sram_size  out  2  0 byte, 1 half, 2 word
- data_sram_addr  out  ADDR_W  bus address
- data_sram_wstrb  out  4  byte write strobes
- data_sram_wdata  out  32  write data
- data_sram_addr_ok  in  1  address accepted
- data_sram_data_ok  in  1  data returned / write done
- data_sram_rdata  in  32  read data

Behaviour:
- Clock and reset: clk is the only clock. rst is synchronous, active-high.
- Reset values: state=IDLE; data_sram_req=0; resp_valid=0; load_data=0; all latched request fields=0.
- Decode (combinational, in IDLE):
  - LW, SW need addr[1:0]==0. LH, LHU, SH need addr[0]==0. Byte ops and LWL/LWR/SWL/SWR are never misaligned.
  - A misaligned access raises addrErrorLw or addrErrorSw in the same cycle, issues no bus request and does not stall.
  - Flags are 0 when req_valid=0 and in every state other than IDLE.
- Store data and strobes:
  - SB: data replicated x4, one-hot wstrb by offset.
  - SH: data replicated x2, wstrb 0011 or 1100.
  - SW: wstrb 1111.
  - SWL, offset 0..3: wstrb 0001/0011/0111/1111, wdata = write_data >> 24/16/8/0.
  - SWR, offset 0..3: wstrb 1111/1110/1100/1000, wdata = write_data << 0/8/16/24.
  - LWL/LWR/SWL/SWR use the word-aligned address and size=2.
- States:
  - IDLE: if req_valid, the op is memory, no address error and no flush, then latch op/addr/offset/rt_old/wdata/strobes, assert data_sram_req and go to REQ. stall_o is high in that cycle.
  - REQ: hold req and all bus fields stable until addr_ok, then drop req and go to WAIT. If data_ok arrives in the same cycle as addr_ok, go straight to DONE. stall_o=1.
  - WAIT: on data_ok, register load_data and go to DONE. stall_o=1.
  - DONE: resp_valid=1 and stall_o=0 for exactly one cycle, then go to IDLE unconditionally. The MEM-stage input is not re-accepted in DONE.
  - CANCEL: entered when flush=1 in REQ or WAIT. A flush in REQ keeps req asserted until addr_ok. Wait for data_ok, discard it, then go to IDLE with no resp_valid. stall_o=req_valid in CANCEL.
- Flush is ignored in DONE. A flush in IDLE suppresses acceptance.
- Load extension:
  - LB/LBU: sign/zero-extend rdata byte[offset].
  - LH/LHU: sign/zero-extend rdata half[offset[1]].
  - LW: rdata.
  - LWL, offset 0..3: {rd[7:0],rt[23:0]}, {rd[15:0],rt[15:0]}, {rd[23:0],rt[7:0]}, rd.
  - LWR, offset 0..3: rd, {rt[31:24],rd[31:8]}, {rt[31:16],rd[31:16]}, {rt[31:8],rd[31:24]}.
  - Stores: load_data=0.
- rst in any state, including with a transaction outstanding, returns to IDLE immediately. The bus-side slave is reset by the same rst.

Decomposition:
- Shared package / defines.vh holds:
  - the EXE_* opcodes, including LWL/LWR/SWL/SWR
  - SIZE_BYTE/HALF/WORD
  - FSM state encodings
- One sub-module: mem_load_ext, combinational byte/half extension plus LWL/LWR merge (op, offset, rdata, rt_old -> load_data).

Test Plan:
1. LW addr=0x80000004, rdata=0x12345678, addr_ok at cycle 2, data_ok at cycle 4 -> stall_o high for cycles 0-4, resp_valid pulse at cycle 5, load_data=0x12345678, size=2.
2. LB addr=0x...3, rdata=0x80FF0011 -> load_data=0xFFFFFF80. LBU -> 0x00000080. LH addr=...2 -> 0xFFFF80FF.
3. SW addr=0x...2 -> addrErrorSw=1 in the same cycle, data_sram_req never asserted, stall_o=0. LH addr=...1 -> addrErrorLw=1.
4. SWL write_data=0xAABBCCDD, addr=...1 -> addr=...0, wstrb=0011, wdata=0x0000AABB. LWR rt_old=0x11223344, addr=...2, rdata=0xA1B2C3D4 -> load_data=0x1122A1B2.
5. flush asserted in REQ before addr_ok -> req held until addr_ok, CANCEL until data_ok, no resp_valid, back to IDLE. The next LW then completes normally.
6. rst pulsed while in WAIT -> next cycle state IDLE, req=0, resp_valid=0, load_data=0.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit:
// MIPS load/store opcodes, bus transfer sizes and the access FSM encoding.
package mem_access_unit_pkg;

  localparam logic [5:0] EXE_LB  = 6'h20;
  localparam logic [5:0] EXE_LH  = 6'h21;
  localparam logic [5:0] EXE_LWL = 6'h22;
  localparam logic [5:0] EXE_LW  = 6'h23;
  localparam logic [5:0] EXE_LBU = 6'h24;
  localparam logic [5:0] EXE_LHU = 6'h25;
  localparam logic [5:0] EXE_LWR = 6'h26;
  localparam logic [5:0] EXE_SB  = 6'h28;
  localparam logic [5:0] EXE_SH  = 6'h29;
  localparam logic [5:0] EXE_SWL = 6'h2a;
  localparam logic [5:0] EXE_SW  = 6'h2b;
  localparam logic [5:0] EXE_SWR = 6'h2e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE,
    ST_CANCEL
  } state_t;

  // Everything captured at acceptance except the address, whose width is a parameter.
  typedef struct packed {
    logic [5:0]  op;
    logic [1:0]  offset;
    logic [31:0] rt_old;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_fields_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// SRAM-like data bus: request/address handshake plus a separate data_ok completion.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        wstrb;
  logic [31:0]       wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [31:0]       rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/mem_load_ext.sv
// Combinational load result shaping: byte/half extension and the LWL/LWR merge with rt.
module mem_load_ext
  import mem_access_unit_pkg::*;
(
  input  logic [5:0]  i_op,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_rt_old,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_offset, 3'b000} +: 8];
  assign w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    // NOTE: default first so every path assigns the output and no latch is inferred.
    o_load_data = '0;
    case (i_op)
      EXE_LB:  o_load_data = {{24{w_byte[7]}}, w_byte};
      EXE_LBU: o_load_data = {24'd0, w_byte};
      EXE_LH:  o_load_data = {{16{w_half[15]}}, w_half};
      EXE_LHU: o_load_data = {16'd0, w_half};
      EXE_LW:  o_load_data = i_rdata;
      EXE_LWL: begin
        case (i_offset)
          2'd0:    o_load_data = {i_rdata[7:0],  i_rt_old[23:0]};
          2'd1:    o_load_data = {i_rdata[15:0], i_rt_old[15:0]};
          2'd2:    o_load_data = {i_rdata[23:0], i_rt_old[7:0]};
          default: o_load_data = i_rdata;
        endcase
      end
      EXE_LWR: begin
        case (i_offset)
          2'd0:    o_load_data = i_rdata;
          2'd1:    o_load_data = {i_rt_old[31:24], i_rdata[31:8]};
          2'd2:    o_load_data = {i_rt_old[31:16], i_rdata[31:16]};
          default: o_load_data = {i_rt_old[31:8],  i_rdata[31:24]};
        endcase
      end
      default: o_load_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage request/response engine: decodes loads/stores, drives the data bus,
// stalls while a transaction is outstanding and drains flushed transactions.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter bit UNALIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [5:0]         op_code,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [31:0]        write_data,
  input  logic [31:0]        rt_old,
  input  logic               flush,
  output logic               stall_o,
  output logic               resp_valid,
  output logic [31:0]        load_data,
  output logic               addrErrorLw,
  output logic               addrErrorSw,
  mem_access_unit_if.master  data_sram
);

  state_t            r_state, w_next;
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  req_fields_t       r_fields;
  logic [31:0]       r_load_data;

  logic              w_is_load, w_is_store, w_mis, w_idle, w_accept;
  logic [ADDR_W-1:0] w_new_addr;
  req_fields_t       w_new;
  logic [31:0]       w_ext_data;

  always_comb begin
    w_is_load      = 1'b0;
    w_is_store     = 1'b0;
    w_mis          = 1'b0;
    w_new_addr     = addr;
    w_new          = '0;
    w_new.op       = op_code;
    w_new.offset   = addr[1:0];
    w_new.rt_old   = rt_old;
    case (op_code)
      EXE_LB, EXE_LBU: begin
        w_is_load  = 1'b1;
        w_new.size = SIZE_BYTE;
      end
      EXE_LH, EXE_LHU: begin
        w_is_load  = 1'b1;
        w_new.size = SIZE_HALF;
        w_mis      = addr[0];
      end
      EXE_LW: begin
        w_is_load  = 1'b1;
        w_new.size = SIZE_WORD;
        w_mis      = |addr[1:0];
      end
      EXE_LWL, EXE_LWR: if (UNALIGNED_EN) begin
        w_is_load  = 1'b1;
        w_new.size = SIZE_WORD;
        w_new_addr = {addr[ADDR_W-1:2], 2'b00};
      end
      EXE_SB: begin
        w_is_store  = 1'b1;
        w_new.size  = SIZE_BYTE;
        w_new.wdata = {4{write_data[7:0]}};
        w_new.wstrb = 4'b0001 << addr[1:0];
      end
      EXE_SH: begin
        w_is_store  = 1'b1;
        w_new.size  = SIZE_HALF;
        w_mis       = addr[0];
        w_new.wdata = {2{write_data[15:0]}};
        w_new.wstrb = addr[1] ? 4'b1100 : 4'b0011;
      end
      EXE_SW: begin
        w_is_store  = 1'b1;
        w_new.size  = SIZE_WORD;
        w_mis       = |addr[1:0];
        w_new.wdata = write_data;
        w_new.wstrb = 4'b1111;
      end
      EXE_SWL, EXE_SWR: if (UNALIGNED_EN) begin
        w_is_store = 1'b1;
        w_new.size = SIZE_WORD;
        w_new_addr = {addr[ADDR_W-1:2], 2'b00};
        if (op_code == EXE_SWL) begin
          w_new.wdata = write_data >> {2'd3 - addr[1:0], 3'b000};
          w_new.wstrb = 4'b1111 >> (2'd3 - addr[1:0]);
        end else begin
          w_new.wdata = write_data << {addr[1:0], 3'b000};
          w_new.wstrb = 4'b1111 << addr[1:0];
        end
      end
      default: ;
    endcase
    w_new.wr = w_is_store;
  end

  assign w_idle      = (r_state == ST_IDLE);
  assign addrErrorLw = w_idle && req_valid && w_is_load  && w_mis;
  assign addrErrorSw = w_idle && req_valid && w_is_store && w_mis;
  assign w_accept    = w_idle && req_valid && (w_is_load || w_is_store) && !w_mis && !flush;

  // A flushed transaction whose data arrives in the same cycle is simply dropped.
  always_comb begin
    w_next  = r_state;
    stall_o = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        stall_o = w_accept;
        if (w_accept) w_next = ST_REQ;
      end
      ST_REQ: begin
        stall_o = 1'b1;
        if (data_sram.addr_ok) begin
          if (data_sram.data_ok) w_next = flush ? ST_IDLE   : ST_DONE;
          else                   w_next = flush ? ST_CANCEL : ST_WAIT;
        end else if (flush) begin
          w_next = ST_CANCEL;
        end
      end
      ST_WAIT: begin
        stall_o = 1'b1;
        if (data_sram.data_ok) w_next = flush ? ST_IDLE : ST_DONE;
        else if (flush)        w_next = ST_CANCEL;
      end
      ST_DONE: w_next = ST_IDLE;
      ST_CANCEL: begin
        stall_o = req_valid;
        if (data_sram.data_ok && (!r_req || data_sram.addr_ok)) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state     <= ST_IDLE;
      r_req       <= 1'b0;
      r_addr      <= '0;
      r_fields    <= '0;
      r_load_data <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_req    <= 1'b1;
        r_addr   <= w_new_addr;
        r_fields <= w_new;
      end else if (r_req && data_sram.addr_ok) begin
        r_req <= 1'b0;
      end
      if (w_next == ST_DONE && r_state != ST_DONE) r_load_data <= w_ext_data;
    end
  end

  mem_load_ext u_load_ext (
    .i_op        (r_fields.op),
    .i_offset    (r_fields.offset),
    .i_rdata     (data_sram.rdata),
    .i_rt_old    (r_fields.rt_old),
    .o_load_data (w_ext_data)
  );

  assign data_sram.req   = r_req;
  assign data_sram.wr    = r_fields.wr;
  assign data_sram.size  = r_fields.size;
  assign data_sram.addr  = r_addr;
  assign data_sram.wstrb = r_fields.wstrb;
  assign data_sram.wdata = r_fields.wdata;

  assign resp_valid = (r_state == ST_DONE);
  assign load_data  = r_load_data;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed loads/stores against a latency-programmable bus slave.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst, req_valid, flush;
  logic [5:0]  op_code;
  logic [31:0] addr, write_data, rt_old;
  logic        stall_o, resp_valid, addrErrorLw, addrErrorSw;
  logic [31:0] load_data;

  mem_access_unit_if #(.ADDR_W(32)) bus ();

  mem_access_unit #(.ADDR_W(32), .UNALIGNED_EN(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .op_code     (op_code),
    .addr        (addr),
    .write_data  (write_data),
    .rt_old      (rt_old),
    .flush       (flush),
    .stall_o     (stall_o),
    .resp_valid  (resp_valid),
    .load_data   (load_data),
    .addrErrorLw (addrErrorLw),
    .addrErrorSw (addrErrorSw),
    .data_sram   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } bus_exp_t;

  bus_exp_t    bus_q[$];
  logic [31:0] load_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  int          s_addr_gap = 0;
  int          s_data_gap = 0;
  logic [31:0] s_rdata    = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_bus(input logic wr, input logic [1:0] size, input logic [31:0] a,
                          input logic [3:0] wstrb, input logic [31:0] wdata);
    bus_exp_t e;
    e.wr = wr; e.size = size; e.addr = a; e.wstrb = wstrb; e.wdata = wdata;
    bus_q.push_back(e);
  endtask

  // Slave: addr_ok after s_addr_gap idle request cycles, data_ok s_data_gap cycles later.
  initial begin
    int ph, cnt;
    ph = 0; cnt = 0;
    bus.addr_ok = 1'b0; bus.data_ok = 1'b0; bus.rdata = 32'hdeadbeef;
    forever begin
      @(negedge clk);
      bus.addr_ok = 1'b0; bus.data_ok = 1'b0; bus.rdata = 32'hdeadbeef;
      if (rst) begin
        ph = 0;
      end else begin
        if (ph == 0 && bus.req) begin ph = 1; cnt = s_addr_gap; end
        if (ph == 1) begin
          if (cnt == 0) begin bus.addr_ok = 1'b1; ph = 2; cnt = s_data_gap; end
          else cnt--;
        end
        if (ph == 2) begin
          if (cnt == 0) begin bus.data_ok = 1'b1; bus.rdata = s_rdata; ph = 0; end
          else cnt--;
        end
      end
    end
  end

  // Monitor: compares bus fields at address acceptance and load_data at each response.
  initial begin
    bus_exp_t    be;
    logic [31:0] el;
    forever begin
      @(negedge clk); #2;
      if (!rst && bus.req && bus.addr_ok) begin
        if (bus_q.size() == 0) check("bus_unexpected_req", 32'd1, 32'd0);
        else begin
          be = bus_q.pop_front();
          check("bus_wr", {31'd0, bus.wr}, {31'd0, be.wr});
          check("bus_size", {30'd0, bus.size}, {30'd0, be.size});
          check("bus_addr", bus.addr, be.addr);
          if (be.wr) begin
            check("bus_wstrb", {28'd0, bus.wstrb}, {28'd0, be.wstrb});
            check("bus_wdata", bus.wdata, be.wdata);
          end
        end
      end
      if (!rst && resp_valid) begin
        if (load_q.size() == 0) check("resp_unexpected", 32'd1, 32'd0);
        else begin
          el = load_q.pop_front();
          check("load_data", load_data, el);
        end
      end
    end
  end

  task automatic run_txn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rt, input int ag, input int dg,
                         input logic [31:0] rd, output int lat);
    s_addr_gap = ag; s_data_gap = dg; s_rdata = rd;
    @(negedge clk);
    req_valid = 1'b1; op_code = op; addr = a; write_data = wd; rt_old = rt;
    #2;
    check("accept_stall", {31'd0, stall_o}, 32'd1);
    lat = -1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      // Scramble the inputs so only latched values can produce the right result.
      req_valid = 1'b0; rt_old = 32'h5a5a5a5a; write_data = 32'hdeadbeef; addr = ~a;
      #2;
      if (!stall_o) lat = c;
    end
    if (lat < 0) check("txn_timeout", 32'd1, 32'd0);
    else begin
      check("resp_pulse", {31'd0, resp_valid}, 32'd1);
      @(negedge clk); #2;
      check("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
    end
  endtask

  task automatic do_vec(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rt, input logic [31:0] rd, input logic [31:0] exp_ld,
                        input logic wr, input logic [1:0] size, input logic [31:0] baddr,
                        input logic [3:0] wstrb, input logic [31:0] wdata, input int ag, input int dg);
    int lat;
    push_bus(wr, size, baddr, wstrb, wdata);
    load_q.push_back(exp_ld);
    run_txn(op, a, wd, rt, ag, dg, rd, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; op_code = '0;
    addr = '0; write_data = '0; rt_old = '0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_req", {31'd0, bus.req}, 32'd0);
    check("rst_resp", {31'd0, resp_valid}, 32'd0);
    check("rst_load", load_data, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Plain LW: addr_ok one cycle after req, data_ok two cycles after addr_ok.
    push_bus(1'b0, SIZE_WORD, 32'h80000004, 4'h0, 32'h0);
    load_q.push_back(32'h12345678);
    run_txn(EXE_LW, 32'h80000004, 32'h0, 32'h0, 1, 2, 32'h12345678, lat);
    check("lw_latency", lat, 32'd5);

    do_vec(EXE_LB,  32'h00100003, 0, 0, 32'h80FF0011, 32'hFFFFFF80, 0, SIZE_BYTE, 32'h00100003, 0, 0, 0, 0);
    do_vec(EXE_LBU, 32'h00100003, 0, 0, 32'h80FF0011, 32'h00000080, 0, SIZE_BYTE, 32'h00100003, 0, 0, 1, 1);
    do_vec(EXE_LH,  32'h00100002, 0, 0, 32'h80FF0011, 32'hFFFF80FF, 0, SIZE_HALF, 32'h00100002, 0, 0, 2, 0);
    do_vec(EXE_LHU, 32'h00100000, 0, 0, 32'h80FF0011, 32'h00000011, 0, SIZE_HALF, 32'h00100000, 0, 0, 0, 2);
    do_vec(EXE_SB,  32'h00100001, 32'h000000A5, 0, 0, 0, 1, SIZE_BYTE, 32'h00100001, 4'b0010, 32'hA5A5A5A5, 1, 0);
    do_vec(EXE_SH,  32'h00100002, 32'h00001234, 0, 0, 0, 1, SIZE_HALF, 32'h00100002, 4'b1100, 32'h12341234, 0, 1);
    do_vec(EXE_SW,  32'h00100008, 32'hCAFEF00D, 0, 0, 0, 1, SIZE_WORD, 32'h00100008, 4'b1111, 32'hCAFEF00D, 2, 2);
    do_vec(EXE_SWL, 32'h00100001, 32'hAABBCCDD, 0, 0, 0, 1, SIZE_WORD, 32'h00100000, 4'b0011, 32'h0000AABB, 1, 1);
    do_vec(EXE_SWR, 32'h00100003, 32'hAABBCCDD, 0, 0, 0, 1, SIZE_WORD, 32'h00100000, 4'b1000, 32'hDD000000, 0, 0);
    do_vec(EXE_LWR, 32'h00100002, 0, 32'h11223344, 32'hA1B2C3D4, 32'h1122A1B2, 0, SIZE_WORD, 32'h00100000, 0, 0, 1, 2);
    do_vec(EXE_LWL, 32'h00100001, 0, 32'h11223344, 32'hA1B2C3D4, 32'hC3D43344, 0, SIZE_WORD, 32'h00100000, 0, 0, 2, 1);

    // addr_ok and data_ok together: REQ goes straight to DONE.
    push_bus(1'b0, SIZE_WORD, 32'h00100000, 4'h0, 32'h0);
    load_q.push_back(32'h76543210);
    run_txn(EXE_LW, 32'h00100000, 32'h0, 32'h0, 0, 0, 32'h76543210, lat);
    check("lw_fast_latency", lat, 32'd2);

    // Misaligned accesses: flag in the same cycle, no request, no stall.
    @(negedge clk);
    req_valid = 1'b1; op_code = EXE_SW; addr = 32'h10000002; #2;
    check("sw_mis_err", {31'd0, addrErrorSw}, 32'd1);
    check("sw_mis_lwflag", {31'd0, addrErrorLw}, 32'd0);
    check("sw_mis_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    op_code = EXE_LH; addr = 32'h10000001; #2;
    check("lh_mis_err", {31'd0, addrErrorLw}, 32'd1);
    check("lh_mis_swflag", {31'd0, addrErrorSw}, 32'd0);
    check("sw_mis_no_req", {31'd0, bus.req}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0; #2;
    check("lh_mis_no_req", {31'd0, bus.req}, 32'd0);
    check("err_gated", {31'd0, addrErrorLw}, 32'd0);

    // Flush in IDLE suppresses acceptance.
    @(negedge clk);
    req_valid = 1'b1; op_code = EXE_LW; addr = 32'h00000100; flush = 1'b1; #2;
    check("idle_flush_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0; #2;
    check("idle_flush_no_req", {31'd0, bus.req}, 32'd0);

    // Flush in REQ: request held to addr_ok, data drained and discarded.
    s_addr_gap = 3; s_data_gap = 2; s_rdata = 32'h0BADF00D;
    push_bus(1'b0, SIZE_WORD, 32'h00000200, 4'h0, 32'h0);
    @(negedge clk);
    req_valid = 1'b1; op_code = EXE_LW; addr = 32'h00000200; #2;
    check("fl_accept_stall", {31'd0, stall_o}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b1; #2;
    check("fl_req_in_req", {31'd0, bus.req}, 32'd1);
    @(negedge clk);
    flush = 1'b0; #2;
    check("fl_req_held", {31'd0, bus.req}, 32'd1);
    check("fl_cancel_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    req_valid = 1'b1; op_code = 6'h00; #2;
    check("fl_cancel_stall_rv", {31'd0, stall_o}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 5; c <= 9; c++) begin
      @(negedge clk); #2;
      check("fl_no_resp", {31'd0, resp_valid}, 32'd0);
      if (c == 5) check("fl_req_dropped", {31'd0, bus.req}, 32'd0);
    end
    check("fl_discard", load_data, 32'h76543210);

    push_bus(1'b0, SIZE_WORD, 32'h00000204, 4'h0, 32'h0);
    load_q.push_back(32'h13579BDF);
    run_txn(EXE_LW, 32'h00000204, 32'h0, 32'h0, 1, 1, 32'h13579BDF, lat);

    // Reset while waiting for data_ok.
    s_addr_gap = 0; s_data_gap = 6; s_rdata = 32'h2468ACE0;
    push_bus(1'b0, SIZE_WORD, 32'h00000300, 4'h0, 32'h0);
    @(negedge clk);
    req_valid = 1'b1; op_code = EXE_LW; addr = 32'h00000300;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk); #2;
    check("rw_wait_stall", {31'd0, stall_o}, 32'd1);
    check("rw_wait_no_req", {31'd0, bus.req}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #2;
    check("rw_req", {31'd0, bus.req}, 32'd0);
    check("rw_resp", {31'd0, resp_valid}, 32'd0);
    check("rw_load", load_data, 32'd0);
    check("rw_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_vec(EXE_SB, 32'h00100002, 32'h0000003C, 0, 0, 0, 1, SIZE_BYTE, 32'h00100002, 4'b0100, 32'h3C3C3C3C, 1, 1);

    repeat (4) @(negedge clk);
    check("bus_q_drained", bus_q.size(), 32'd0);
    check("load_q_drained", load_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
